diff_accumulator: RTL and testbench

DIFF_ACCUMULATOR -- requirements
Module: diff_accumulator

---
 rtl/diff_accumulator_pkg.sv | 22 ++
 rtl/diff_accumulator_if.sv | 26 ++
 rtl/diff_accumulator_sum_out_slice.sv | 44 ++++
 rtl/diff_accumulator.sv | 96 +++++++++
 tb/tb_diff_accumulator.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/diff_accumulator_pkg.sv
// Shared widths, types and the accumulator sizing rule for the difference accumulator.
package diff_accumulator_pkg;

  localparam int DATA_BITS = 8;
  localparam int CNT_BITS  = 8;

  typedef logic [DATA_BITS-1:0] data_t;
  typedef logic [CNT_BITS-1:0]  cnt_t;

  // Smallest accumulator width that holds nsamp full-scale samples without wrapping.
  function automatic int min_acc_bits(input int nsamp);
    int max_sum;
    int bits;
    max_sum = nsamp * ((1 << DATA_BITS) - 1);
    bits    = 0;
    for (int i = 0; i < 31; i++) begin
      if ((max_sum >> i) != 0) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/diff_accumulator_if.sv
// Sample input handshake, flush request and window-sum output handshake.
interface diff_accumulator_if #(
  parameter int ACC_BITS = 16
);
  import diff_accumulator_pkg::*;

  data_t               in_data;
  logic                in_valid;
  logic                in_ready;
  logic                flush;
  logic [ACC_BITS-1:0] out_sum;
  cnt_t                out_cnt;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_sum, out_cnt, out_valid
  );

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_sum, out_cnt, out_valid
  );

endinterface

// File: rtl/diff_accumulator_sum_out_slice.sv
// One-entry output register holding a finished window sum until downstream takes it.
module sum_out_slice
  import diff_accumulator_pkg::*;
#(
  parameter int ACC_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [ACC_BITS-1:0] load_sum,
  input  cnt_t                load_cnt,
  input  logic                out_ready,
  output logic [ACC_BITS-1:0] out_sum,
  output cnt_t                out_cnt,
  output logic                out_valid,
  output logic                free
);

  logic [ACC_BITS-1:0] sum_p1;
  cnt_t                cnt_p1;
  logic                vld_p1;

  // The slot can take a new window when empty or being drained this cycle.
  assign free      = !vld_p1 || out_ready;
  assign out_sum   = sum_p1;
  assign out_cnt   = cnt_p1;
  assign out_valid = vld_p1;

  // Load a finished window, or retire the held one on an output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_p1 <= '0;
      cnt_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (load) begin
      sum_p1 <= load_sum;
      cnt_p1 <= load_cnt;
      vld_p1 <= 1'b1;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

endmodule

// File: rtl/diff_accumulator.sv
// Sums NSAMP unsigned difference words per window; FLUSH closes a partial window early.
module diff_accumulator
  import diff_accumulator_pkg::*;
#(
  parameter int NSAMP    = 4,
  parameter int ACC_BITS = 16
) (
  input logic          clk,
  input logic          rst,
  diff_accumulator_if.slave bus
);

  generate
    if (NSAMP < 2 || NSAMP > 255) begin : g_bad_nsamp
      $error("diff_accumulator: NSAMP must lie in 2..255");
    end
    if (ACC_BITS < min_acc_bits(NSAMP)) begin : g_bad_acc_bits
      $error("diff_accumulator: ACC_BITS too narrow for NSAMP full-scale samples");
    end
  endgenerate

  localparam cnt_t LAST_CNT = cnt_t'(NSAMP - 1);
  localparam cnt_t FULL_CNT = cnt_t'(NSAMP);

  // Zero-extend the sample into the accumulator; legal widths never wrap.
  function automatic logic [ACC_BITS-1:0] add_sample(input logic [ACC_BITS-1:0] a,
                                                     input data_t d);
    return a + ACC_BITS'(d);
  endfunction

  logic [ACC_BITS-1:0] acc_p0;
  cnt_t                cnt_p0;
  logic                out_free;
  logic                cnt_last;
  logic                in_hs;
  logic                load;
  logic [ACC_BITS-1:0] sum_nxt;
  logic [ACC_BITS-1:0] load_sum;
  cnt_t                load_cnt;

  // Only the window-closing sample can be refused, and only while the output slot is busy.
  assign cnt_last     = (cnt_p0 == LAST_CNT);
  assign bus.in_ready = !(cnt_last && !out_free);
  assign in_hs        = bus.in_valid && bus.in_ready;
  assign sum_nxt      = add_sample(acc_p0, bus.in_data);

  // Decide whether this edge closes a window, and with which sum and count.
  always_comb begin
    load     = 1'b0;
    load_sum = sum_nxt;
    load_cnt = cnt_p0 + cnt_t'(1);
    if (in_hs) begin
      if (cnt_last) begin
        load     = 1'b1;
        load_cnt = FULL_CNT;
      end else if (bus.flush && out_free) begin
        load = 1'b1;
      end
    end else if (bus.flush && (cnt_p0 != '0) && out_free) begin
      load     = 1'b1;
      load_sum = acc_p0;
      load_cnt = cnt_p0;
    end
  end

  // Stage p0: running window sum and sample count, cleared whenever a window closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (load) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (in_hs) begin
      acc_p0 <= sum_nxt;
      cnt_p0 <= cnt_p0 + cnt_t'(1);
    end
  end

  // Stage p1: finished window held for the downstream handshake.
  sum_out_slice #(
    .ACC_BITS (ACC_BITS)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_sum  (load_sum),
    .load_cnt  (load_cnt),
    .out_ready (bus.out_ready),
    .out_sum   (bus.out_sum),
    .out_cnt   (bus.out_cnt),
    .out_valid (bus.out_valid),
    .free      (out_free)
  );

endmodule

// File: tb/tb_diff_accumulator.sv
// Scoreboard bench: window-level reference model feeds an expected queue, a monitor checks outputs.
module tb_diff_accumulator;
  import diff_accumulator_pkg::*;

  localparam int NS = 4;
  localparam int AB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  diff_accumulator_if #(.ACC_BITS(AB)) bus ();
  diff_accumulator_if #(.ACC_BITS(16)) big ();

  diff_accumulator #(.NSAMP(NS), .ACC_BITS(AB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  diff_accumulator #(.NSAMP(255), .ACC_BITS(16)) dut_big (
    .clk (clk),
    .rst (rst),
    .bus (big)
  );

  typedef struct {
    int sum;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   win[$];
  bit   pending = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One clock of stimulus; the model works on the list of samples in the open window.
  task automatic cyc(input bit v, input int d, input bit f, input bit r);
    bit free, rdy, hs, load;
    int s;
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = 8'(d);
    bus.flush     = f;
    bus.out_ready = r;
    free = !pending || r;
    rdy  = !((win.size() == NS - 1) && !free);
    hs   = v && rdy;
    load = 1'b0;
    if (hs) begin
      win.push_back(d);
      if (win.size() == NS || (f && free)) load = 1'b1;
    end else if (f && win.size() > 0 && free) begin
      load = 1'b1;
    end
    if (load) begin
      s = 0;
      foreach (win[i]) s += win[i];
      exp_q.push_back('{s, win.size()});
      win.delete();
    end
    pending = load || (pending && !r);
    #1;
    check("in_ready", bus.in_ready, rdy);
  endtask

  task automatic chk_out(input string name, input int sum, input int cnt);
    check({name, "_valid"}, bus.out_valid, 1);
    check({name, "_sum"}, bus.out_sum, sum);
    check({name, "_cnt"}, bus.out_cnt, cnt);
  endtask

  task automatic do_reset_mid();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_out_cnt", bus.out_cnt, 0);
    check("rst_in_ready", bus.in_ready, 1);
    win.delete();
    exp_q.delete();
    pending      = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    @(posedge clk);
    #3;
    check("rst_in_ready_held", bus.in_ready, 1);
    rst = 1'b0;
  endtask

  // Monitor: compare any presented output with the oldest expected window; pop on handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_valid_unexpected", bus.out_valid, 0);
      end else begin
        check("out_sum", bus.out_sum, exp_q[0].sum);
        check("out_cnt", bus.out_cnt, exp_q[0].cnt);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int stalls;
    bit found;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    big.in_valid  = 1'b0;
    big.in_data   = '0;
    big.flush     = 1'b0;
    big.out_ready = 1'b0;

    #1 rst = 1'b1;
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_sum", bus.out_sum, 0);
    check("reset_out_cnt", bus.out_cnt, 0);
    check("reset_in_ready", bus.in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    // Full window with free-flowing output.
    cyc(1, 10, 0, 1);
    cyc(1, 20, 0, 1);
    cyc(1, 30, 0, 1);
    cyc(1, 40, 0, 1);
    cyc(0, 0, 0, 1);
    chk_out("fill", 100, 4);
    cyc(0, 0, 0, 1);
    check("fill_valid_drop", bus.out_valid, 0);
    check("fill_sum_hold", bus.out_sum, 100);

    // Backpressure: second window's closing sample waits for the output slot.
    for (int i = 1; i <= 7; i++) cyc(1, i, 0, 0);
    cyc(1, 8, 0, 0);
    check("bp_in_ready_low", bus.in_ready, 0);
    cyc(1, 8, 0, 0);
    cyc(1, 8, 0, 1);
    cyc(0, 0, 0, 1);
    chk_out("bp_second", 26, 4);
    cyc(0, 0, 0, 1);

    // Flush alone and flush with a coincident sample.
    cyc(1, 5, 0, 1);
    cyc(1, 7, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    chk_out("flush_alone", 12, 2);
    cyc(1, 5, 0, 1);
    cyc(1, 7, 0, 1);
    cyc(1, 9, 1, 1);
    cyc(0, 0, 0, 1);
    chk_out("flush_with_sample", 21, 3);

    // Flush on an empty window does nothing.
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    check("flush_empty_no_out", bus.out_valid, 0);

    // Flush while the output is stalled is dropped; a later retry succeeds.
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 0);
    cyc(1, 3, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk_out("flush_stalled_hold", 4, 4);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    chk_out("flush_retry", 5, 2);

    // Reset in mid-window, then a clean window.
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
    do_reset_mid();
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 1);
    chk_out("post_reset", 4, 4);

    // Reset with a stalled output pending discards it.
    for (int i = 0; i < 3; i++) cyc(1, 9, 0, 0);
    cyc(1, 9, 0, 0);
    do_reset_mid();

    // Randomized traffic.
    repeat (400) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 255),
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
    end

    repeat (8) cyc(0, 0, 0, 1);
    check("drain_left", exp_q.size(), 0);

    // Largest window at full scale on the NSAMP=255 instance.
    stalls = 0;
    for (int i = 0; i < 255; i++) begin
      @(posedge clk);
      #1;
      big.in_valid  = 1'b1;
      big.in_data   = 8'd255;
      big.out_ready = 1'b1;
      #1;
      if (!big.in_ready) stalls++;
    end
    @(posedge clk);
    #1 big.in_valid = 1'b0;
    #1;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (big.out_valid) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    check("big_in_ready_stalls", stalls, 0);
    check("big_out_valid", found, 1);
    check("big_out_sum", big.out_sum, 65025);
    check("big_out_cnt", big.out_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
